// File: rtl/vx_data_flush_pkg.sv
// Shared definitions for the cache bank flush sequencer: address width and FSM encoding.
package vx_data_flush_pkg;

  localparam int unsigned ADDR_WIDTH = 32;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StScan  = 3'd1,
    StSend  = 3'd2,
    StClean = 3'd3,
    StDone  = 3'd4
  } flush_state_e;

endpackage

// File: rtl/vx_data_flush.sv
// Flush/writeback sequencer for one cache bank: walks every line, writes back dirty bytes
// to memory, then clears the line's dirty mask with a fill write.
module vx_data_flush
  import vx_data_flush_pkg::*;
#(
  parameter int unsigned CACHE_SIZE      = 16384,
  parameter int unsigned CACHE_LINE_SIZE = 64,
  parameter int unsigned NUM_BANKS       = 1,
  parameter int unsigned WORD_SIZE       = 4,
  parameter int unsigned BANK_ID         = 0,
  localparam int unsigned LINES_PER_BANK   = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS),
  localparam int unsigned LINE_SELECT_BITS = $clog2(LINES_PER_BANK),
  localparam int unsigned BANK_SELECT_BITS = $clog2(NUM_BANKS),
  localparam int unsigned LINE_ADDR_WIDTH  = ADDR_WIDTH - $clog2(CACHE_LINE_SIZE),
  localparam int unsigned TAG_SELECT_BITS  = LINE_ADDR_WIDTH - LINE_SELECT_BITS - BANK_SELECT_BITS,
  localparam int unsigned CACHE_LINE_WIDTH = (CACHE_LINE_SIZE / WORD_SIZE) * WORD_SIZE * 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_flush_start,
  output logic                        o_flush_busy,
  output logic                        o_flush_done,
  output logic [LINE_SELECT_BITS-1:0] o_ds_read_addr,
  input  logic [CACHE_LINE_WIDTH-1:0] i_ds_read_data,
  input  logic [CACHE_LINE_SIZE-1:0]  i_ds_read_dirtyb,
  input  logic                        i_tag_read_valid,
  input  logic [TAG_SELECT_BITS-1:0]  i_tag_read_tag,
  output logic                        o_ds_write_enable,
  output logic                        o_ds_write_fill,
  output logic [CACHE_LINE_SIZE-1:0]  o_ds_byte_enable,
  output logic [LINE_SELECT_BITS-1:0] o_ds_write_addr,
  output logic [CACHE_LINE_WIDTH-1:0] o_ds_write_data,
  output logic                        o_mem_req_valid,
  input  logic                        i_mem_req_ready,
  output logic [LINE_ADDR_WIDTH-1:0]  o_mem_req_addr,
  output logic [CACHE_LINE_SIZE-1:0]  o_mem_req_byteen,
  output logic [CACHE_LINE_WIDTH-1:0] o_mem_req_data
);

  flush_state_e                r_state;
  flush_state_e                w_state_next;
  logic [LINE_SELECT_BITS-1:0] r_line_ctr;
  logic [CACHE_LINE_WIDTH-1:0] r_data;
  logic [CACHE_LINE_SIZE-1:0]  r_dirtyb;
  logic [TAG_SELECT_BITS-1:0]  r_tag;
  logic                        w_line_dirty;
  logic                        w_last_line;

  assign w_line_dirty = i_tag_read_valid && (|i_ds_read_dirtyb);
  assign w_last_line  = (r_line_ctr == LINE_SELECT_BITS'(LINES_PER_BANK - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_flush_start) w_state_next = StScan;
      StScan: begin
        if (w_line_dirty) begin
          w_state_next = StSend;
        end else if (w_last_line) begin
          w_state_next = StDone;
        end
      end
      StSend:  if (i_mem_req_ready) w_state_next = StClean;
      StClean: w_state_next = w_last_line ? StDone : StScan;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // The counter saturates at the last line; the FSM leaves SCAN/CLEAN there instead.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_line_ctr <= '0;
      r_data     <= '0;
      r_dirtyb   <= '0;
      r_tag      <= '0;
    end else begin
      if (r_state == StIdle && i_flush_start) begin
        r_line_ctr <= '0;
      end else if ((r_state == StScan && !w_line_dirty && !w_last_line) ||
                   (r_state == StClean && !w_last_line)) begin
        r_line_ctr <= r_line_ctr + 1'b1;
      end
      if (r_state == StScan && w_line_dirty) begin
        r_data   <= i_ds_read_data;
        r_dirtyb <= i_ds_read_dirtyb;
        r_tag    <= i_tag_read_tag;
      end
    end
  end

  always_comb begin
    o_flush_busy      = (r_state != StIdle);
    o_flush_done      = (r_state == StDone);
    o_mem_req_valid   = (r_state == StSend);
    o_ds_write_enable = 1'b0;
    o_ds_write_fill   = 1'b0;
    o_ds_byte_enable  = '0;
    o_ds_write_addr   = '0;
    o_ds_write_data   = '0;
    if (r_state == StClean) begin
      o_ds_write_enable = 1'b1;
      o_ds_write_fill   = 1'b1;
      o_ds_byte_enable  = '1;
      o_ds_write_addr   = r_line_ctr;
      o_ds_write_data   = r_data;
    end
  end

  assign o_ds_read_addr   = r_line_ctr;
  assign o_mem_req_byteen = r_dirtyb;
  assign o_mem_req_data   = r_data;

  if (NUM_BANKS == 1) begin : g_no_bank
    logic w_unused_bank;
    assign w_unused_bank  = ^BANK_ID;
    assign o_mem_req_addr = {r_tag, r_line_ctr};
  end else begin : g_bank
    assign o_mem_req_addr = {r_tag, r_line_ctr, BANK_SELECT_BITS'(BANK_ID)};
  end

endmodule
